// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: address/control sequencer for the in-place radix-2
// FFT datapath. Read side walks a butterfly counter per stage; write side is
// the read request delayed by the PE pipeline latency.
module fft_stage_sequencer #(
   parameter int ADDR_W   = 6,
   parameter int STAGES   = 7,
   parameter int PIPE_LAT = 2
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              start,
   input  logic              hold,
   output logic              busy,
   output logic              done,
   output logic [3:0]        stage,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr0,
   output logic [ADDR_W-1:0] rd_addr1,
   output logic              rd_swap,
   output logic [ADDR_W-1:0] tf_addr,
   output logic              bypass_n,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr0,
   output logic [ADDR_W-1:0] wr_addr1,
   output logic              wr_swap
);

   localparam int DW = $clog2(PIPE_LAT) + 1;
   localparam logic [ADDR_W-1:0] ONES = '1;

   typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_FINISH} state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] a0;
      logic [ADDR_W-1:0] a1;
      logic              swap;
   } wr_req_t;

   state_t            state, state_nx;
   logic [ADDR_W-1:0] c, c_nx;
   logic [3:0]        stage_q, stage_nx;
   logic [DW-1:0]     dcnt, dcnt_nx;
   logic [ADDR_W-1:0] mask, sw_bits;
   logic [3:0]        sw_sh;
   wr_req_t           rd_req;
   logic [PIPE_LAT:1] vld_pipe;
   wr_req_t           req_pipe [PIPE_LAT:1];

   // State, butterfly counter, drain counter and stage index; all frozen by hold.
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state   <= S_IDLE;
         c       <= '0;
         stage_q <= '0;
         dcnt    <= '0;
      end else begin
         state   <= state_nx;
         c       <= c_nx;
         stage_q <= stage_nx;
         dcnt    <= dcnt_nx;
      end
   end

   // Next-state: DRAIN waits for the last PIPE_LAT writes so the next stage
   // never reads a word before it has been written back.
   always_comb begin
      state_nx = state;
      c_nx     = c;
      stage_nx = stage_q;
      dcnt_nx  = dcnt;
      if (!hold) begin
         case (state)
            S_IDLE: if (start) begin
               state_nx = S_READ;
               c_nx     = '0;
               stage_nx = '0;
            end
            S_READ: begin
               c_nx = c + 1'b1;
               if (c == ONES) begin
                  state_nx = S_DRAIN;
                  dcnt_nx  = '0;
               end
            end
            S_DRAIN: begin
               dcnt_nx = dcnt + 1'b1;
               if (dcnt == DW'(PIPE_LAT - 1)) begin
                  if (stage_q == 4'(STAGES - 1)) begin
                     state_nx = S_FINISH;
                  end else begin
                     state_nx = S_READ;
                     stage_nx = stage_q + 4'd1;
                  end
               end
            end
            default: begin
               state_nx = S_IDLE;
               stage_nx = '0;
            end
         endcase
      end
   end

   // Read-side address generation from counter and stage; zero outside READ.
   always_comb begin
      mask     = ~(ONES >> stage_q);
      sw_sh    = 4'(ADDR_W) - stage_q;
      sw_bits  = c >> sw_sh;
      rd_en    = (state == S_READ);
      rd_addr0 = c;
      rd_addr1 = '0;
      rd_swap  = 1'b0;
      tf_addr  = '0;
      bypass_n = 1'b1;
      if (rd_en) begin
         rd_addr1 = c ^ mask;
         rd_swap  = (stage_q != 4'd0) && sw_bits[0];
         tf_addr  = c << stage_q;
         bypass_n = (stage_q != 4'(STAGES - 1));
      end
      rd_req = '{a0: rd_addr0, a1: rd_addr1, swap: rd_swap};
   end

   // Write-side delay line matching the PE latency; stalls with hold.
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         vld_pipe <= '0;
         for (int i = 1; i <= PIPE_LAT; i++) req_pipe[i] <= '0;
      end else if (!hold) begin
         vld_pipe[1] <= rd_en;
         req_pipe[1] <= rd_req;
         for (int i = 2; i <= PIPE_LAT; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            req_pipe[i] <= req_pipe[i-1];
         end
      end
   end

   assign wr_en    = vld_pipe[PIPE_LAT] & ~hold;
   assign wr_addr0 = req_pipe[PIPE_LAT].a0;
   assign wr_addr1 = req_pipe[PIPE_LAT].a1;
   assign wr_swap  = req_pipe[PIPE_LAT].swap;
   assign stage    = stage_q;
   assign busy     = (state == S_READ) || (state == S_DRAIN);
   assign done     = (state == S_FINISH) && !hold;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer: two instances (PIPE_LAT 2 and 4) share the
// stimulus; each is compared every cycle against a model that tracks only the
// number of non-hold cycles since start acceptance.
module tb_fft_stage_sequencer;
   localparam int AW = 6;
   localparam int ST = 7;
   localparam int D  = 64;
   localparam int LA = 2;
   localparam int LB = 4;

   logic Clk, Reset_n, start, hold;
   logic busy_a, done_a, rd_en_a, rd_swap_a, bypass_n_a, wr_en_a, wr_swap_a;
   logic busy_b, done_b, rd_en_b, rd_swap_b, bypass_n_b, wr_en_b, wr_swap_b;
   logic [3:0] stage_a, stage_b;
   logic [AW-1:0] rd_addr0_a, rd_addr1_a, tf_addr_a, wr_addr0_a, wr_addr1_a;
   logic [AW-1:0] rd_addr0_b, rd_addr1_b, tf_addr_b, wr_addr0_b, wr_addr1_b;
   logic [40:0] obs_a, obs_b, ea, eb;

   int n_tests = 0, n_fail = 0, cyc = 0;
   bit act [2];
   int k   [2];
   int lat [2] = '{LA, LB};

   fft_stage_sequencer #(.ADDR_W(AW), .STAGES(ST), .PIPE_LAT(LA)) dut_a (
      .Clk(Clk), .Reset_n(Reset_n), .start(start), .hold(hold),
      .busy(busy_a), .done(done_a), .stage(stage_a), .rd_en(rd_en_a),
      .rd_addr0(rd_addr0_a), .rd_addr1(rd_addr1_a), .rd_swap(rd_swap_a),
      .tf_addr(tf_addr_a), .bypass_n(bypass_n_a), .wr_en(wr_en_a),
      .wr_addr0(wr_addr0_a), .wr_addr1(wr_addr1_a), .wr_swap(wr_swap_a));

   fft_stage_sequencer #(.ADDR_W(AW), .STAGES(ST), .PIPE_LAT(LB)) dut_b (
      .Clk(Clk), .Reset_n(Reset_n), .start(start), .hold(hold),
      .busy(busy_b), .done(done_b), .stage(stage_b), .rd_en(rd_en_b),
      .rd_addr0(rd_addr0_b), .rd_addr1(rd_addr1_b), .rd_swap(rd_swap_b),
      .tf_addr(tf_addr_b), .bypass_n(bypass_n_b), .wr_en(wr_en_b),
      .wr_addr0(wr_addr0_b), .wr_addr1(wr_addr1_b), .wr_swap(wr_swap_b));

   assign obs_a = {busy_a, done_a, stage_a, rd_en_a, rd_addr0_a, rd_addr1_a, rd_swap_a,
                   tf_addr_a, bypass_n_a, wr_en_a, wr_addr0_a, wr_addr1_a, wr_swap_a};
   assign obs_b = {busy_b, done_b, stage_b, rd_en_b, rd_addr0_b, rd_addr1_b, rd_swap_b,
                   tf_addr_b, bypass_n_b, wr_en_b, wr_addr0_b, wr_addr1_b, wr_swap_b};

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Read issued at effective cycle kk of a run (kk=1 is the first READ cycle).
   function automatic void rd_at(input int kk, input int L, output bit en, output int c,
                                 output int s, output int a1, output bit swp, output int tf);
      int P;
      P = D + L;
      en = 0; c = 0; s = 0; a1 = 0; swp = 0; tf = 0;
      if (kk >= 1 && kk <= ST * P && (kk - 1) % P < D) begin
         en  = 1;
         c   = (kk - 1) % P;
         s   = (kk - 1) / P;
         a1  = c ^ (D - D / (2 ** s));
         swp = (s != 0) && ((c / (2 ** (AW - s))) % 2 == 1);
         tf  = (c * (2 ** s)) % D;
      end
   endfunction

   function automatic logic [40:0] exp_vec(bit a, int kk, bit hd, int L);
      int tot, c, s, a1, tf, cw, sw, w1, tfw;
      bit en, swp, wen, wswp, bsy, dn, byp;
      logic [3:0] stg;
      tot = ST * (D + L);
      en = 0; c = 0; s = 0; a1 = 0; swp = 0; tf = 0;
      wen = 0; cw = 0; sw = 0; w1 = 0; wswp = 0;
      if (a) begin
         rd_at(kk, L, en, c, s, a1, swp, tf);
         rd_at(kk - L, L, wen, cw, sw, w1, wswp, tfw);
      end
      bsy = a && kk <= tot;
      dn  = a && kk == tot + 1 && !hd;
      stg = !a ? 4'd0 : (kk <= tot ? 4'((kk - 1) / (D + L)) : 4'(ST - 1));
      byp = !(en && s == ST - 1);
      return {bsy, dn, stg, en, 6'(c), 6'(a1), swp, 6'(tf), byp,
              wen && !hd, 6'(cw), 6'(w1), wswp};
   endfunction

   task automatic tick(bit st, bit hd, bit rn);
      start = st; hold = hd; Reset_n = rn;
      @(posedge Clk);
      cyc++;
      for (int d = 0; d < 2; d++) begin
         if (!rn) begin
            act[d] = 0; k[d] = 0;
         end else if (!hd) begin
            if (!act[d]) begin
               if (st) begin act[d] = 1; k[d] = 1; end
            end else begin
               k[d]++;
               if (k[d] > ST * (D + lat[d]) + 1) begin act[d] = 0; k[d] = 0; end
            end
         end
      end
      ea = exp_vec(act[0], k[0], hd, LA);
      eb = exp_vec(act[1], k[1], hd, LB);
      @(negedge Clk);
   endtask

   task automatic run_to_idle();
      int n;
      n = 0;
      while ((act[0] || act[1]) && n < 1200) begin
         tick(0, 0, 1);
         n++;
         n_tests += 2;
         if (obs_a !== ea) begin n_fail++; $display("FAIL idle_a cyc=%0d got=%h exp=%h", cyc, obs_a, ea); end
         if (obs_b !== eb) begin n_fail++; $display("FAIL idle_b cyc=%0d got=%h exp=%h", cyc, obs_b, eb); end
      end
      n_tests++;
      if (act[0] || act[1]) begin n_fail++; $display("FAIL idle_timeout got=busy exp=idle"); end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         tick(i == 1, 0, 0);
         n_tests += 2;
         if (obs_a !== ea) begin n_fail++; $display("FAIL reset_a got=%h exp=%h", obs_a, ea); end
         if (obs_b !== eb) begin n_fail++; $display("FAIL reset_b got=%h exp=%h", obs_b, eb); end
      end
   endtask

   task automatic test_full_run();
      int acc, nda, ndb, ta, tb;
      nda = 0; ndb = 0; ta = -1; tb = -1;
      for (int i = 0; i < 5; i++) tick(0, 0, 1);
      tick(1, 0, 1);
      acc = cyc;
      for (int i = 0; i < 500; i++) begin
         n_tests += 2;
         if (obs_a !== ea) begin n_fail++; $display("FAIL run_a cyc=%0d got=%h exp=%h", cyc, obs_a, ea); end
         if (obs_b !== eb) begin n_fail++; $display("FAIL run_b cyc=%0d got=%h exp=%h", cyc, obs_b, eb); end
         if (done_a) begin nda++; ta = cyc; end
         if (done_b) begin ndb++; tb = cyc; end
         if (act[0] && k[0] == 3 * (D + LA) + 22) begin
            n_tests += 3;
            if (rd_addr1_a !== (6'h15 ^ 6'h38)) begin n_fail++; $display("FAIL s3_addr1 got=%h exp=%h", rd_addr1_a, 6'h15 ^ 6'h38); end
            if (tf_addr_a !== 6'h28) begin n_fail++; $display("FAIL s3_tf got=%h exp=28", tf_addr_a); end
            if (rd_swap_a !== 1'b0) begin n_fail++; $display("FAIL s3_swap got=%b exp=0", rd_swap_a); end
         end
         if (act[0] && k[0] == 6 * (D + LA) + 10) begin
            n_tests += 2;
            if (bypass_n_a !== 1'b0) begin n_fail++; $display("FAIL s6_bypass got=%b exp=0", bypass_n_a); end
            if (rd_addr1_a !== ~rd_addr0_a) begin n_fail++; $display("FAIL s6_addr1 got=%h exp=%h", rd_addr1_a, ~rd_addr0_a); end
         end
         tick(0, 0, 1);
      end
      n_tests += 4;
      if (nda !== 1) begin n_fail++; $display("FAIL done_count_a got=%0d exp=1", nda); end
      if (ndb !== 1) begin n_fail++; $display("FAIL done_count_b got=%0d exp=1", ndb); end
      if (ta !== acc + ST * (D + LA)) begin n_fail++; $display("FAIL done_time_a got=%0d exp=%0d", ta, acc + ST * (D + LA)); end
      if (tb !== acc + ST * (D + LB)) begin n_fail++; $display("FAIL done_time_b got=%0d exp=%0d", tb, acc + ST * (D + LB)); end
      run_to_idle();
   endtask

   task automatic test_hold();
      int acc, held, ta;
      bit hd;
      held = 0; ta = -1;
      tick(1, 0, 1);
      acc = cyc;
      for (int i = 0; i < 500; i++) begin
         hd = act[0] && k[0] == 21 && held < 5;
         if (hd) held++;
         tick(0, hd, 1);
         n_tests += 2;
         if (obs_a !== ea) begin n_fail++; $display("FAIL hold_a cyc=%0d got=%h exp=%h", cyc, obs_a, ea); end
         if (obs_b !== eb) begin n_fail++; $display("FAIL hold_b cyc=%0d got=%h exp=%h", cyc, obs_b, eb); end
         if (done_a) ta = cyc;
      end
      n_tests++;
      if (ta !== acc + ST * (D + LA) + 5) begin n_fail++; $display("FAIL hold_done_time got=%0d exp=%0d", ta, acc + ST * (D + LA) + 5); end
      run_to_idle();
   endtask

   task automatic test_back_to_back();
      bit st;
      int nda;
      nda = 0;
      tick(1, 0, 1);
      for (int i = 0; i < 600 && act[0]; i++) begin
         st = ($urandom_range(0, 3) == 0) || (k[0] == ST * (D + LA) + 1);
         tick(st, 0, 1);
         n_tests += 2;
         if (obs_a !== ea) begin n_fail++; $display("FAIL b2b_a cyc=%0d got=%h exp=%h", cyc, obs_a, ea); end
         if (obs_b !== eb) begin n_fail++; $display("FAIL b2b_b cyc=%0d got=%h exp=%h", cyc, obs_b, eb); end
         if (done_a) nda++;
      end
      n_tests += 2;
      if (nda !== 1) begin n_fail++; $display("FAIL b2b_single_run got=%0d exp=1", nda); end
      tick(1, 0, 1);
      if (busy_a !== 1'b1) begin n_fail++; $display("FAIL b2b_restart got=%b exp=1", busy_a); end
      run_to_idle();
   endtask

   task automatic test_midrun_reset();
      int n;
      n = 0;
      tick(1, 0, 1);
      while (!(act[0] && k[0] == 2 * (D + LA) + 31) && n < 400) begin tick(0, 0, 1); n++; end
      n_tests++;
      if (rd_addr0_a !== 6'd30 || stage_a !== 4'd2) begin n_fail++; $display("FAIL rst_point got=%0d/%0d exp=2/30", stage_a, rd_addr0_a); end
      tick(0, 0, 0);
      for (int i = 0; i < 20; i++) begin
         n_tests += 2;
         if (obs_a !== ea) begin n_fail++; $display("FAIL midrst_a cyc=%0d got=%h exp=%h", cyc, obs_a, ea); end
         if (obs_b !== eb) begin n_fail++; $display("FAIL midrst_b cyc=%0d got=%h exp=%h", cyc, obs_b, eb); end
         tick(i == 10, 0, 1);
      end
      run_to_idle();
   endtask

   task automatic test_random();
      bit st, hd, rn;
      for (int i = 0; i < 3000; i++) begin
         st = $urandom_range(0, 7) == 0;
         hd = $urandom_range(0, 7) == 0;
         rn = $urandom_range(0, 699) != 0;
         tick(st, hd, rn);
         n_tests += 2;
         if (obs_a !== ea) begin n_fail++; $display("FAIL rand_a cyc=%0d got=%h exp=%h", cyc, obs_a, ea); end
         if (obs_b !== eb) begin n_fail++; $display("FAIL rand_b cyc=%0d got=%h exp=%h", cyc, obs_b, eb); end
      end
      run_to_idle();
   endtask

   initial begin
      start = 0; hold = 0; Reset_n = 0;
      test_reset();
      test_full_run();
      test_hold();
      test_back_to_back();
      test_midrun_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
